// File: rtl/cp0_intc.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_intc
//  Brief    : Coprocessor-0 interrupt/exception controller (SR, Cause, EPC,
//             PRId) for the P7 MIPS core.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_intc #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h1622_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  sel,
    input  logic        we,
    input  logic [31:0] din,
    input  logic        eret,
    output logic [31:0] dout,
    output logic        int_req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] c_sel_sr    = 5'd12;
    localparam logic [4:0] c_sel_cause = 5'd13;
    localparam logic [4:0] c_sel_epc   = 5'd14;
    localparam logic [4:0] c_sel_prid  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_irq_pend;
    logic [31:0] w_pc_aligned;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused;

    assign w_irq_pend   = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign int_req      = w_irq_pend | (exc_req & ~r_exl);

    // A delay-slot victim restarts at the branch so the branch re-executes.
    assign w_pc_aligned = {pc[31:2], 2'b00};
    assign w_epc_next   = bd ? (w_pc_aligned - 32'd4) : w_pc_aligned;

    assign w_sr         = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause      = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

    assign epc_out      = r_epc;
    assign handler_pc   = HANDLER_ADDR;

    assign w_unused     = ^{pc[1:0], din[31:16], din[9:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= hw_int;
            if (int_req) begin
                // The flushed instruction's MTC0/ERET is discarded.
                r_exl      <= 1'b1;
                r_bd       <= bd;
                r_exc_code <= w_irq_pend ? 5'd0 : exc_code;
                r_epc      <= w_epc_next;
            end else begin
                if (we && (sel == c_sel_sr)) begin
                    r_im  <= din[15:10];
                    r_exl <= din[1];
                    r_ie  <= din[0];
                end
                if (we && (sel == c_sel_epc)) begin
                    r_epc <= din;
                end
                // Placed last so ERET's clear overrides an SR write of EXL.
                if (eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (sel)
            c_sel_sr:    dout = w_sr;
            c_sel_cause: dout = w_cause;
            c_sel_epc:   dout = r_epc;
            c_sel_prid:  dout = PRID_VALUE;
            default:     dout = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_intc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_intc
//  Brief    : Self-checking bench for cp0_intc against a word-level CP0 model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_intc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        bd;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic [4:0]  sel;
    logic        we;
    logic [31:0] din;
    logic        eret;
    logic [31:0] dout;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int n_vec = 0;
    int n_err = 0;

    // Reference state held as architectural 32-bit register words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    logic        m_valid = 1'b0;

    cp0_intc dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .bd         (bd),
        .exc_req    (exc_req),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .sel        (sel),
        .we         (we),
        .din        (din),
        .eret       (eret),
        .dout       (dout),
        .int_req    (int_req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_irq();
        return ((m_cause[15:10] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_take();
        return model_irq() || (exc_req && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_dout(input logic [4:0] s);
        case (s)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h1622_0001;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update();
        logic        irq;
        logic        take;
        logic [31:0] base;
        irq  = model_irq();
        take = model_take();
        if (reset) begin
            m_sr    = 32'h0;
            m_cause = 32'h0;
            m_epc   = 32'h0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (take) begin
                base         = pc & 32'hFFFF_FFFC;
                m_epc        = bd ? base - 32'd4 : base;
                m_cause[31]  = bd;
                m_cause[6:2] = irq ? 5'd0 : exc_code;
                m_sr[1]      = 1'b1;
            end else begin
                if (we && sel == 5'd12) m_sr = din & 32'h0000_FC03;
                if (we && sel == 5'd14) m_epc = din;
                if (eret) m_sr[1] = 1'b0;
            end
            m_cause[15:10] = hw_int;
        end
    endtask

    // Check combinational outputs mid-cycle, then advance one clock edge.
    task automatic cycle();
        @(negedge clk);
        if (m_valid) begin
            chk("int_req", {31'b0, int_req}, {31'b0, model_take()});
            chk("dout", dout, model_dout(sel));
            chk("epc_out", epc_out, m_epc);
            chk("handler_pc", handler_pc, 32'h0000_4180);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        pc       = 32'h0;
        bd       = 1'b0;
        exc_req  = 1'b0;
        exc_code = 5'd0;
        hw_int   = 6'd0;
        sel      = 5'd0;
        we       = 1'b0;
        din      = 32'h0;
        eret     = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [4:0] s, input logic [31:0] exp);
        sel = s;
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state
        peek("rst_sr", 5'd12, 32'h0);
        peek("rst_cause", 5'd13, 32'h0);
        peek("rst_epc", 5'd14, 32'h0);
        peek("rst_prid", 5'd15, 32'h1622_0001);
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_epc_out", epc_out, 32'h0);
        cycle();

        // Timer0 interrupt with IM0/IE enabled
        we = 1'b1; sel = 5'd12; din = 32'h0000_0401;
        cycle();
        idle();
        hw_int = 6'b000001; pc = 32'h3010;
        #1 chk("irq_before_ip", {31'b0, int_req}, 32'h0);
        cycle();
        chk("irq_after_ip", {31'b0, int_req}, 32'h1);
        cycle();
        peek("irq_epc", 5'd14, 32'h3010);
        peek("irq_cause", 5'd13, 32'h0000_0400);
        peek("irq_sr", 5'd12, 32'h0000_0403);
        chk("exl_blocks", {31'b0, int_req}, 32'h0);
        cycle();
        cycle();

        // ERET, then the still-pending IRQ re-asserts
        eret = 1'b1;
        #1 chk("eret_epc_out", epc_out, 32'h3010);
        chk("eret_no_irq", {31'b0, int_req}, 32'h0);
        cycle();
        eret = 1'b0;
        #1 chk("irq_reassert", {31'b0, int_req}, 32'h1);
        peek("eret_sr", 5'd12, 32'h0000_0401);
        hw_int = 6'd0;
        cycle();
        idle();
        we = 1'b1; sel = 5'd12; din = 32'h0000_0401;
        cycle();
        idle();

        // Exception in a delay slot
        exc_req = 1'b1; exc_code = 5'd12; bd = 1'b1; pc = 32'h3020;
        #1 chk("exc_int_req", {31'b0, int_req}, 32'h1);
        cycle();
        idle();
        peek("exc_epc", 5'd14, 32'h301C);
        peek("exc_cause", 5'd13, 32'h8000_0030);

        // Writes to Cause are ignored
        we = 1'b1; sel = 5'd13; din = 32'hFFFF_FFFF;
        cycle();
        idle();
        peek("cause_ro", 5'd13, 32'h8000_0030);

        // Interrupt beats exception; same-cycle MTC0 to EPC dropped
        we = 1'b1; sel = 5'd12; din = 32'h0000_0801;
        cycle();
        idle();
        hw_int = 6'b000010;
        cycle();
        exc_req = 1'b1; exc_code = 5'd4; pc = 32'h3040;
        we = 1'b1; sel = 5'd14; din = 32'hDEAD_BEEF;
        #1 chk("prio_int_req", {31'b0, int_req}, 32'h1);
        cycle();
        idle();
        peek("prio_epc", 5'd14, 32'h3040);
        peek("prio_cause", 5'd13, 32'h0000_0800);

        // ERET clear of EXL wins over SR write of din[1]
        we = 1'b1; sel = 5'd12; din = 32'h0000_0002; eret = 1'b1;
        cycle();
        idle();
        peek("eret_vs_mtc0", 5'd12, 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            pc       = $urandom;
            bd       = 1'($urandom);
            exc_req  = ($urandom_range(0, 7) == 0);
            exc_code = 5'($urandom);
            hw_int   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            we       = ($urandom_range(0, 3) == 0);
            sel      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            din      = $urandom;
            eret     = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 / interrupt controller for the P7 MIPS core.
- Consumes the IRQ lines from timer0/timer1 and other bridge devices as hw_int[5:0], holds the SR, Cause, EPC and PRId registers, and decides each cycle whether the pipeline takes an interrupt or exception.
- Serves MFC0/MTC0 accesses and ERET.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC driven on handler_pc.
- PRID_VALUE, 32'h1622_0001, constant returned for register 15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  PC of the instruction currently in the commit stage (victim).
- bd  in  1  victim is in a branch delay slot.
- exc_req  in  1  synchronous exception detected on victim this cycle.
- exc_code  in  5  ExcCode for exc_req.
- hw_int  in  6  device interrupt lines; bit 0 = timer0 IRQ, bit 1 = timer1 IRQ, bit 2 = external.
- sel  in  5  CP0 register number for MFC0/MTC0.
- we  in  1  MTC0 write strobe.
- din  in  32  MTC0 write data.
- eret  in  1  ERET committing this cycle.
- dout  out  32  MFC0 read data, combinational on sel.
- int_req  out  1  take exception/interrupt this cycle; pipeline flushes and redirects to handler_pc.
- epc_out  out  32  current EPC, ERET target.
- handler_pc  out  32  constant HANDLER_ADDR.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits 0.
  - EPC(14): 32 bits.
  - PRId(15): PRID_VALUE.
- Reset: SR=0, Cause=0, EPC=0. Outputs: int_req=0, dout per sel, epc_out=0.
- IP sampling: Cause.IP <= hw_int every cycle, unconditionally, including while EXL=1. One-cycle latency: a timer IRQ rising at edge N appears in IP after edge N+1.
- Interrupt pending: irq_pend = |(IP & IM) & IE & ~EXL.
- int_req (combinational): irq_pend | (exc_req & ~EXL). Exceptions and interrupts arriving while EXL=1 are ignored (no nesting).
- Priority: irq_pend beats exc_req. If both, take the interrupt with ExcCode=0; the exception is re-raised when the instruction re-executes.
- On int_req, at the clock edge:
  - EXL<=1.
  - Cause.BD<=bd.
  - Cause.ExcCode <= irq_pend ? 5'd0 : exc_code.
  - EPC <= bd ? {pc[31:2],2'b00}-4 : {pc[31:2],2'b00}.
- MTC0 (we=1, no int_req):
  - sel=12: IM, EXL, IE loaded from din[15:10], din[1], din[0].
  - sel=14: EPC<=din.
  - sel=13, sel=15 and any other sel: write ignored.
- ERET (eret=1, no int_req): EXL<=0 at the edge. epc_out is already valid combinationally for the redirect.
- Simultaneous events:
  - int_req with we or eret in the same cycle: int_req wins; the MTC0/ERET is dropped because that instruction is flushed.
  - we to sel=12 with eret: eret's EXL clear wins over din[1]; IM/IE still written.
  - An interrupt is never taken in the ERET cycle: EXL is still 1.
- dout:
  - sel 12/13/14/15 return SR/Cause/EPC/PRId; other sel return 0.
  - Reads see register state before the current edge; there is no write-through bypass.
- Reset mid-handler: EXL cleared, and any pending interrupt is masked because IE=0.

Test Plan:
- Reset, then MFC0 sel=12,13,14,15 -> 0, 0, 0, 32'h1622_0001; int_req=0.
- MTC0 SR=32'h0000_0401 (IM0, IE). Raise hw_int[0] at cycle N with pc=32'h3010 -> int_req=1 in cycle N+1; after the edge EPC=32'h3010, ExcCode=0, EXL=1, Cause.IP[10]=1.
- Hold hw_int[0]=1 while EXL=1 -> int_req stays 0. Issue eret -> epc_out=32'h3010 and EXL=0 after the edge; int_req re-asserts the following cycle.
- With EXL=0, assert exc_req with exc_code=5'd12 and bd=1 at pc=32'h3020 -> EPC=32'h301C, BD=1, ExcCode=12.
- Assert exc_req (code 4) and an enabled hw_int[1] in the same cycle, plus we to sel=14 -> ExcCode=0, EPC=pc, MTC0 data discarded.
- we to sel=13 with din=32'hFFFF_FFFF -> Cause unchanged. we to sel=12 with din=32'h0000_0002 in the same cycle as eret -> EXL=0.
